// File: rtl/instr_decode.sv
// -----------------------------------------------------------------------------
// instr_decode
//
// RV32I instruction decoder for the JARVIS front end. It sits between fetch and
// register read/issue. One 32-bit instruction word is accepted every cycle.
// The compact decode is registered with one cycle of latency. There is no stall
// and no handshake.
//
// Ports:
//   clk              rising-edge clock
//   rst              asynchronous, active-high reset (all outputs -> 0)
//   instr[31:0]      instruction word, sampled every rising edge
//   op[5:0]          internal opcode (0 = INVALID)
//   rs1_v / rs1[4:0] source register 1 used / specifier (0 when unused)
//   rs2_v / rs2[4:0] source register 2 used / specifier (0 when unused)
//   rd_v  / rd[4:0]  destination written / specifier (0 when unused)
//   imm_v / imm[31:0] immediate present / decoded immediate (0 when absent)
//   load_store_instr instruction is a load or store (op 0B..12)
//
// Build option:
//   INSTR_DECODE_M_EXT_EN  when defined, decodes the M-extension multiply and
//                          divide group (op 29..30). Otherwise those encodings
//                          are INVALID.
// -----------------------------------------------------------------------------
module instr_decode (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   output logic [5:0]  op,
   output logic        rs1_v,
   output logic [4:0]  rs1,
   output logic        rs2_v,
   output logic [4:0]  rs2,
   output logic        rd_v,
   output logic [4:0]  rd,
   output logic        imm_v,
   output logic [31:0] imm,
   output logic        load_store_instr
);

   typedef enum logic [5:0] {
      OP_INVALID = 6'h00, OP_LUI   = 6'h01, OP_AUIPC = 6'h02, OP_JAL   = 6'h03,
      OP_JALR    = 6'h04, OP_BEQ   = 6'h05, OP_BNE   = 6'h06, OP_BLT   = 6'h07,
      OP_BGE     = 6'h08, OP_BLTU  = 6'h09, OP_BGEU  = 6'h0A, OP_LB    = 6'h0B,
      OP_LH      = 6'h0C, OP_LW    = 6'h0D, OP_LBU   = 6'h0E, OP_LHU   = 6'h0F,
      OP_SB      = 6'h10, OP_SH    = 6'h11, OP_SW    = 6'h12, OP_ADDI  = 6'h13,
      OP_SLTI    = 6'h14, OP_SLTIU = 6'h15, OP_XORI  = 6'h16, OP_ORI   = 6'h17,
      OP_ANDI    = 6'h18, OP_SLLI  = 6'h19, OP_SRLI  = 6'h1A, OP_SRAI  = 6'h1B,
      OP_ADD     = 6'h1C, OP_SUB   = 6'h1D, OP_SLL   = 6'h1E, OP_SLT   = 6'h1F,
      OP_SLTU    = 6'h20, OP_XOR   = 6'h21, OP_OR    = 6'h22, OP_AND   = 6'h23,
      OP_SRL     = 6'h24, OP_SRA   = 6'h25, OP_FENCE = 6'h26, OP_ECALL = 6'h27,
      OP_EBREAK  = 6'h28, OP_MUL   = 6'h29
   } op_e;

   // Operand format selects which fields and which immediate layout apply.
   // FMT_NONE covers INVALID and the system/fence group (no operands).
   typedef enum logic [2:0] {
      FMT_NONE, FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J
   } fmt_e;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];

   // ---- stage p0: combinational decode of the incoming word ----
   op_e         op_p0;
   fmt_e        fmt_p0;
   logic        ls_p0;
   logic        rs1_v_p0, rs2_v_p0, rd_v_p0, imm_v_p0;
   logic [4:0]  rs1_p0, rs2_p0, rd_p0;
   logic [31:0] imm_p0;

   always_comb begin
      op_p0  = OP_INVALID;
      fmt_p0 = FMT_NONE;
      ls_p0  = 1'b0;
      case (opcode)
         7'b0110111: begin op_p0 = OP_LUI;   fmt_p0 = FMT_U; end
         7'b0010111: begin op_p0 = OP_AUIPC; fmt_p0 = FMT_U; end
         7'b1101111: begin op_p0 = OP_JAL;   fmt_p0 = FMT_J; end
         7'b1100111: begin
            if (funct3 == 3'b000) begin
               op_p0  = OP_JALR;
               fmt_p0 = FMT_I;
            end
         end
         7'b1100011: begin
            fmt_p0 = FMT_B;
            case (funct3)
               3'b000:  op_p0 = OP_BEQ;
               3'b001:  op_p0 = OP_BNE;
               3'b100:  op_p0 = OP_BLT;
               3'b101:  op_p0 = OP_BGE;
               3'b110:  op_p0 = OP_BLTU;
               3'b111:  op_p0 = OP_BGEU;
               default: fmt_p0 = FMT_NONE;
            endcase
         end
         7'b0000011: begin
            fmt_p0 = FMT_I;
            ls_p0  = 1'b1;
            case (funct3)
               3'b000:  op_p0 = OP_LB;
               3'b001:  op_p0 = OP_LH;
               3'b010:  op_p0 = OP_LW;
               3'b100:  op_p0 = OP_LBU;
               3'b101:  op_p0 = OP_LHU;
               default: begin fmt_p0 = FMT_NONE; ls_p0 = 1'b0; end
            endcase
         end
         7'b0100011: begin
            fmt_p0 = FMT_S;
            ls_p0  = 1'b1;
            case (funct3)
               3'b000:  op_p0 = OP_SB;
               3'b001:  op_p0 = OP_SH;
               3'b010:  op_p0 = OP_SW;
               default: begin fmt_p0 = FMT_NONE; ls_p0 = 1'b0; end
            endcase
         end
         7'b0010011: begin
            fmt_p0 = FMT_I;
            case (funct3)
               3'b000: op_p0 = OP_ADDI;
               3'b010: op_p0 = OP_SLTI;
               3'b011: op_p0 = OP_SLTIU;
               3'b100: op_p0 = OP_XORI;
               3'b110: op_p0 = OP_ORI;
               3'b111: op_p0 = OP_ANDI;
               3'b001: begin
                  if (funct7 == 7'b0000000) begin
                     op_p0  = OP_SLLI;
                     fmt_p0 = FMT_SH;
                  end else begin
                     fmt_p0 = FMT_NONE;
                  end
               end
               default: begin // 3'b101: SRLI / SRAI split on funct7
                  if (funct7 == 7'b0000000) begin
                     op_p0  = OP_SRLI;
                     fmt_p0 = FMT_SH;
                  end else if (funct7 == 7'b0100000) begin
                     op_p0  = OP_SRAI;
                     fmt_p0 = FMT_SH;
                  end else begin
                     fmt_p0 = FMT_NONE;
                  end
               end
            endcase
         end
         7'b0110011: begin
            case (funct7)
               7'b0000000: begin
                  fmt_p0 = FMT_R;
                  case (funct3)
                     3'b000:  op_p0 = OP_ADD;
                     3'b001:  op_p0 = OP_SLL;
                     3'b010:  op_p0 = OP_SLT;
                     3'b011:  op_p0 = OP_SLTU;
                     3'b100:  op_p0 = OP_XOR;
                     3'b101:  op_p0 = OP_SRL;
                     3'b110:  op_p0 = OP_OR;
                     default: op_p0 = OP_AND;
                  endcase
               end
               7'b0100000: begin
                  fmt_p0 = FMT_R;
                  case (funct3)
                     3'b000:  op_p0 = OP_SUB;
                     3'b101:  op_p0 = OP_SRA;
                     default: fmt_p0 = FMT_NONE;
                  endcase
               end
`ifdef INSTR_DECODE_M_EXT_EN
               7'b0000001: begin
                  // MUL..REMU are contiguous, ordered by funct3.
                  fmt_p0 = FMT_R;
                  op_p0  = op_e'(OP_MUL + {3'b000, funct3});
               end
`endif
               default: ;
            endcase
         end
         7'b0001111: begin
            if (funct3 == 3'b000) op_p0 = OP_FENCE;
         end
         7'b1110011: begin
            // ECALL/EBREAK differ only in imm[0]; every other field must be zero.
            if (instr[31:7] == 25'd0)
               op_p0 = OP_ECALL;
            else if (instr[31:7] == 25'h0002000)
               op_p0 = OP_EBREAK;
         end
         default: ;
      endcase
   end

   // Operand fields follow the format only; register value x0 is still valid.
   always_comb begin
      rs1_v_p0 = 1'b0;
      rs2_v_p0 = 1'b0;
      rd_v_p0  = 1'b0;
      imm_v_p0 = 1'b0;
      imm_p0   = 32'd0;
      case (fmt_p0)
         FMT_R: begin
            rs1_v_p0 = 1'b1; rs2_v_p0 = 1'b1; rd_v_p0 = 1'b1;
         end
         FMT_I: begin
            rs1_v_p0 = 1'b1; rd_v_p0 = 1'b1; imm_v_p0 = 1'b1;
            imm_p0   = {{20{instr[31]}}, instr[31:20]};
         end
         FMT_SH: begin
            rs1_v_p0 = 1'b1; rd_v_p0 = 1'b1; imm_v_p0 = 1'b1;
            imm_p0   = {27'd0, instr[24:20]};
         end
         FMT_S: begin
            rs1_v_p0 = 1'b1; rs2_v_p0 = 1'b1; imm_v_p0 = 1'b1;
            imm_p0   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         end
         FMT_B: begin
            rs1_v_p0 = 1'b1; rs2_v_p0 = 1'b1; imm_v_p0 = 1'b1;
            imm_p0   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                        instr[11:8], 1'b0};
         end
         FMT_U: begin
            rd_v_p0  = 1'b1; imm_v_p0 = 1'b1;
            imm_p0   = {instr[31:12], 12'd0};
         end
         FMT_J: begin
            rd_v_p0  = 1'b1; imm_v_p0 = 1'b1;
            imm_p0   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                        instr[30:21], 1'b0};
         end
         default: ;
      endcase
   end

   assign rs1_p0 = rs1_v_p0 ? instr[19:15] : 5'd0;
   assign rs2_p0 = rs2_v_p0 ? instr[24:20] : 5'd0;
   assign rd_p0  = rd_v_p0  ? instr[11:7]  : 5'd0;

   // ---- stage p1: registered outputs (reset value equals INVALID decode) ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op               <= 6'd0;
         rs1_v            <= 1'b0;
         rs1              <= 5'd0;
         rs2_v            <= 1'b0;
         rs2              <= 5'd0;
         rd_v             <= 1'b0;
         rd               <= 5'd0;
         imm_v            <= 1'b0;
         imm              <= 32'd0;
         load_store_instr <= 1'b0;
      end else begin
         op               <= op_p0;
         rs1_v            <= rs1_v_p0;
         rs1              <= rs1_p0;
         rs2_v            <= rs2_v_p0;
         rs2              <= rs2_p0;
         rd_v             <= rd_v_p0;
         rd               <= rd_p0;
         imm_v            <= imm_v_p0;
         imm              <= imm_p0;
         load_store_instr <= ls_p0;
      end
   end

endmodule

// File: tb/tb_instr_decode.sv
// -----------------------------------------------------------------------------
// tb_instr_decode
//
// Directed-vector bench for instr_decode. Each vector carries hand-computed
// expected outputs; every comparison goes through the check task.
// -----------------------------------------------------------------------------
module tb_instr_decode;

   logic        clk;
   logic        rst;
   logic [31:0] instr;
   logic [5:0]  op;
   logic        rs1_v, rs2_v, rd_v, imm_v, load_store_instr;
   logic [4:0]  rs1, rs2, rd;
   logic [31:0] imm;

   int n_checks = 0;
   int n_errors = 0;

   instr_decode dut (
      .clk              (clk),
      .rst              (rst),
      .instr            (instr),
      .op               (op),
      .rs1_v            (rs1_v),
      .rs1              (rs1),
      .rs2_v            (rs2_v),
      .rs2              (rs2),
      .rd_v             (rd_v),
      .rd               (rd),
      .imm_v            (imm_v),
      .imm              (imm),
      .load_store_instr (load_store_instr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic check_all(input string name, input logic [5:0] e_op,
                            input logic e_rs1_v, input logic [4:0] e_rs1,
                            input logic e_rs2_v, input logic [4:0] e_rs2,
                            input logic e_rd_v,  input logic [4:0] e_rd,
                            input logic e_imm_v, input logic [31:0] e_imm,
                            input logic e_ls);
      check({name, ".op"},    {26'd0, op},              {26'd0, e_op});
      check({name, ".rs1_v"}, {31'd0, rs1_v},           {31'd0, e_rs1_v});
      check({name, ".rs1"},   {27'd0, rs1},             {27'd0, e_rs1});
      check({name, ".rs2_v"}, {31'd0, rs2_v},           {31'd0, e_rs2_v});
      check({name, ".rs2"},   {27'd0, rs2},             {27'd0, e_rs2});
      check({name, ".rd_v"},  {31'd0, rd_v},            {31'd0, e_rd_v});
      check({name, ".rd"},    {27'd0, rd},              {27'd0, e_rd});
      check({name, ".imm_v"}, {31'd0, imm_v},           {31'd0, e_imm_v});
      check({name, ".imm"},   imm,                      e_imm);
      check({name, ".ls"},    {31'd0, load_store_instr}, {31'd0, e_ls});
   endtask

   task automatic check_zero(input string name);
      check_all(name, 6'h00, 0, 0, 0, 0, 0, 0, 0, 32'd0, 0);
   endtask

   // Drive a word on the falling edge, then sample just after the rising edge.
   task automatic step(input logic [31:0] w);
      @(negedge clk);
      instr = w;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst   = 1'b1;
      instr = 32'd0;
      #3;
      check_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      step(32'h3E808093); check_all("addi1000", 6'h13, 1, 1, 0, 0, 1, 1, 1, 32'd1000, 0);

      // Back-to-back words, one per cycle.
      step(32'h4B008093); check_all("addi1200", 6'h13, 1, 1, 0, 0, 1, 1, 1, 32'd1200, 0);
      step(32'h57808093); check_all("addi1400", 6'h13, 1, 1, 0, 0, 1, 1, 1, 32'd1400, 0);
      step(32'h64008093); check_all("addi1600", 6'h13, 1, 1, 0, 0, 1, 1, 1, 32'd1600, 0);
      step(32'h70808093); check_all("addi1800", 6'h13, 1, 1, 0, 0, 1, 1, 1, 32'd1800, 0);

      // Output must not follow instr between edges.
      #1 instr = 32'hFFFFFFFF;
      #1 check("hold.op", {26'd0, op}, 32'h13);

      step(32'hFFC12083); check_all("lw",   6'h0D, 1, 2, 0, 0, 1, 1, 1, 32'hFFFFFFFC, 1);
      step(32'h00112223); check_all("sw",   6'h12, 1, 2, 1, 1, 0, 0, 1, 32'd4, 1);
      step(32'h40208033); check_all("sub",  6'h1D, 1, 1, 1, 2, 1, 0, 0, 32'd0, 0);
      step(32'hFE000EE3); check_all("beq",  6'h05, 1, 0, 1, 0, 0, 0, 1, 32'hFFFFFFFC, 0);
      step(32'h123450B7); check_all("lui",  6'h01, 0, 0, 0, 0, 1, 1, 1, 32'h12345000, 0);
      step(32'h008000EF); check_all("jal",  6'h03, 0, 0, 0, 0, 1, 1, 1, 32'd8, 0);
      step(32'h4020D093); check_all("srai", 6'h1B, 1, 1, 0, 0, 1, 1, 1, 32'd2, 0);
      step(32'h00000073); check_all("ecall",  6'h27, 0, 0, 0, 0, 0, 0, 0, 32'd0, 0);
      step(32'h00100073); check_all("ebreak", 6'h28, 0, 0, 0, 0, 0, 0, 0, 32'd0, 0);

      step(32'h022080B3);
`ifdef INSTR_DECODE_M_EXT_EN
      check_all("mul", 6'h29, 1, 1, 1, 2, 1, 1, 0, 32'd0, 0);
`else
      check_zero("mul");
`endif
      step(32'hFFFFFFFF); check_zero("allones");

      // Asynchronous reset in the middle of the stream.
      step(32'h3E808093); check_all("pre_rst", 6'h13, 1, 1, 0, 0, 1, 1, 1, 32'd1000, 0);
      @(negedge clk);
      #1 rst = 1'b1;
      #1 check_zero("rst_async");
      @(posedge clk);
      #1 check_zero("rst_hold");
      @(negedge clk);
      rst   = 1'b0;
      instr = 32'h4B008093;
      @(posedge clk);
      #1 check_all("post_rst", 6'h13, 1, 1, 0, 0, 1, 1, 1, 32'd1200, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
